// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the 16-bit RISC core.
// Owns the PC, tracks two-word LDM instructions so the immediate word is flagged, and handles stall/redirect.
module fetch_stage #(
    parameter int                  PC_WIDTH   = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [15:0]         NOP_WORD   = 16'hF800,
    parameter logic [4:0]          LDM_OPCODE = 5'b00111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_data,
    output logic [15:0]         inst_out,
    output logic [15:0]         last_out,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                imm_flag,
    output logic                valid_out
);

    typedef enum logic {
        NORMAL,
        IMM
    } fetch_state_t;

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;

    assign imem_addr = pc;

    // A word fetched in IMM is always data, so an immediate that looks like an LDM never re-arms the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            inst_out  <= NOP_WORD;
            last_out  <= NOP_WORD;
            pc_out    <= RESET_PC;
            imm_flag  <= 1'b0;
            valid_out <= 1'b0;
            state     <= NORMAL;
        end else if (redirect_valid) begin
            pc        <= redirect_pc;
            inst_out  <= NOP_WORD;
            last_out  <= NOP_WORD;
            pc_out    <= redirect_pc;
            imm_flag  <= 1'b0;
            valid_out <= 1'b0;
            state     <= NORMAL;
        end else if (!stall) begin
            pc        <= pc + PC_WIDTH'(1);
            last_out  <= inst_out;
            inst_out  <= imem_data;
            pc_out    <= pc;
            valid_out <= 1'b1;
            case (state)
                NORMAL: begin
                    imm_flag <= 1'b0;
                    if (imem_data[15:11] == LDM_OPCODE) begin
                        state <= IMM;
                    end
                end
                IMM: begin
                    imm_flag <= 1'b1;
                    state    <= NORMAL;
                end
                default: begin
                    imm_flag <= 1'b0;
                    state    <= NORMAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: a fetched-word history model checked every cycle,
// plus literal expectations at key points of the directed sequence.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'hF800;
    localparam logic [4:0]  LDM = 5'b00111;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] word;
        logic        imm;
    } fetch_rec_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] inst_out;
    logic [15:0] last_out;
    logic [15:0] pc_out;
    logic        imm_flag;
    logic        valid_out;

    logic [15:0] mem [0:65535];

    int tests = 0;
    int fails = 0;

    fetch_rec_t  hist[$];
    logic [15:0] m_pc;
    bit          m_started = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .inst_out       (inst_out),
        .last_out       (last_out),
        .pc_out         (pc_out),
        .imm_flag       (imm_flag),
        .valid_out      (valid_out)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the IF/ID register shows the last two words fetched since the most recent flush.
    // A word is an immediate exactly when the previous fetched word was an LDM that was not itself an immediate.
    initial begin
        fetch_rec_t rec;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pc = 16'h0000;
                hist.delete();
                m_started = 1;
            end else if (redirect_valid) begin
                m_pc = redirect_pc;
                hist.delete();
            end else if (!stall) begin
                rec.addr = m_pc;
                rec.word = mem[m_pc];
                rec.imm  = (hist.size() > 0) && (hist[$].word[15:11] == LDM) && !hist[$].imm;
                hist.push_back(rec);
                if (hist.size() > 2) void'(hist.pop_front());
                m_pc = m_pc + 16'd1;
            end
        end
    end

    initial begin
        logic [15:0] e_inst, e_last;
        logic        e_valid, e_imm;
        forever begin
            @(negedge clk);
            if (m_started) begin
                e_valid = hist.size() > 0;
                e_inst  = e_valid ? hist[$].word : NOP;
                e_last  = (hist.size() > 1) ? hist[hist.size()-2].word : NOP;
                e_imm   = e_valid && hist[$].imm;
                cmp("model imem_addr", imem_addr, m_pc);
                cmp("model inst_out", inst_out, e_inst);
                cmp("model last_out", last_out, e_last);
                cmp("model valid_out", {15'b0, valid_out}, {15'b0, e_valid});
                cmp("model imm_flag", {15'b0, imm_flag}, {15'b0, e_imm});
                if (e_valid) cmp("model pc_out", pc_out, hist[$].addr);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic s, input logic rv, input logic [15:0] rpc);
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] e_inst, input logic [15:0] e_last,
                               input logic [15:0] e_pcout, input logic e_imm, input logic e_valid,
                               input logic [15:0] e_addr);
        cmp({name, " inst_out"}, inst_out, e_inst);
        cmp({name, " last_out"}, last_out, e_last);
        cmp({name, " pc_out"}, pc_out, e_pcout);
        cmp({name, " imm_flag"}, {15'b0, imm_flag}, {15'b0, e_imm});
        cmp({name, " valid_out"}, {15'b0, valid_out}, {15'b0, e_valid});
        cmp({name, " imem_addr"}, imem_addr, e_addr);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h8000 | 16'(i & 16'h07FF);
        mem[0]      = 16'h2800;
        mem[1]      = 16'h1000;
        mem[2]      = 16'h8000;
        mem[3]      = 16'h4000;
        mem[4]      = 16'h3800;
        mem[5]      = 16'h3800;
        mem[6]      = 16'h1000;
        mem[7]      = 16'h5007;
        mem[9]      = 16'h3801;
        mem[10]     = 16'h0000;
        mem[16'h40] = 16'h6040;
        mem[16'hFFFF] = 16'h7FFF;

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        #2;

        // Reset then free-run
        applyStimulus(1, 0, 0, 16'h0000);
        checkOutput("reset", NOP, NOP, 16'h0000, 0, 0, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("run0", 16'h2800, NOP, 16'h0000, 0, 1, 16'h0001);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("run1", 16'h1000, 16'h2800, 16'h0001, 0, 1, 16'h0002);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("run2", 16'h8000, 16'h1000, 16'h0002, 0, 1, 16'h0003);
        applyStimulus(0, 0, 0, 16'h0000);

        // LDM whose immediate looks like another LDM
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("ldm word", 16'h3800, 16'h4000, 16'h0004, 0, 1, 16'h0005);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("ldm imm", 16'h3800, 16'h3800, 16'h0005, 1, 1, 16'h0006);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("after imm", 16'h1000, 16'h3800, 16'h0006, 0, 1, 16'h0007);

        // Stall three cycles, then release
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 16'h0000);
            checkOutput("stall", 16'h1000, 16'h3800, 16'h0006, 0, 1, 16'h0007);
        end
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("release", 16'h5007, 16'h1000, 16'h0007, 0, 1, 16'h0008);

        // Redirect while the FSM waits for an immediate
        applyStimulus(0, 0, 0, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("ldm pending", 16'h3801, 16'h8008, 16'h0009, 0, 1, 16'h000A);
        applyStimulus(0, 0, 1, 16'h0040);
        checkOutput("redirect", NOP, NOP, 16'h0040, 0, 0, 16'h0040);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("post redirect", 16'h6040, NOP, 16'h0040, 0, 1, 16'h0041);

        // Redirect beats stall; reset beats redirect
        applyStimulus(0, 1, 1, 16'h0100);
        cmp("redir+stall addr", imem_addr, 16'h0100);
        cmp("redir+stall inst", inst_out, NOP);
        cmp("redir+stall valid", {15'b0, valid_out}, 16'h0000);
        applyStimulus(1, 0, 1, 16'h0200);
        checkOutput("rst+redir", NOP, NOP, 16'h0000, 0, 0, 16'h0000);

        // PC wrap
        applyStimulus(0, 0, 1, 16'hFFFF);
        cmp("wrap redirect addr", imem_addr, 16'hFFFF);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("wrap0", 16'h7FFF, NOP, 16'hFFFF, 0, 1, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("wrap1", 16'h2800, 16'h7FFF, 16'h0000, 0, 1, 16'h0001);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
